// File: rtl/midi_pkg.sv
// rtl/midi_pkg.sv - shared MIDI constants, command encoding and status-byte helper
package midi_pkg;

  localparam int CLK_FREQ  = 100_000_000;
  localparam int MIDI_BAUD = 31250;
  localparam int CLKS_PER_BIT_DEFAULT = CLK_FREQ / MIDI_BAUD;

  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] CC       = 4'hB;
  localparam logic [3:0] PB       = 4'hE;

  typedef enum logic [1:0] {
    CMD_NOTE_OFF = 2'd0,
    CMD_NOTE_ON  = 2'd1,
    CMD_CC       = 2'd2,
    CMD_PB       = 2'd3
  } cmd_type_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND_STATUS,
    ST_SEND_D1,
    ST_SEND_D2
  } tx_state_e;

  function automatic logic [7:0] status_byte(input logic [1:0] cmd_type,
                                             input logic [3:0] channel);
    logic [3:0] nib;
    case (cmd_type)
      CMD_NOTE_OFF: nib = NOTE_OFF;
      CMD_NOTE_ON:  nib = NOTE_ON;
      CMD_CC:       nib = CC;
      default:      nib = PB;
    endcase
    return {nib, channel};
  endfunction

endpackage

// File: rtl/midi_tx_if.sv
// rtl/midi_tx_if.sv - event handshake between an event source and midi_tx
interface midi_tx_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_type;
  logic [3:0] channel;
  logic [6:0] data1;
  logic [6:0] data2;

  modport master (
    output cmd_valid, cmd_type, channel, data1, data2,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_type, channel, data1, data2,
    output cmd_ready
  );

endinterface

// File: rtl/midi_tx_byte.sv
// rtl/midi_tx_byte.sv - 8N1 byte serializer, LSB first, idle high
// ready also rises in the last stop-bit cycle so a following byte starts with no gap.
module midi_tx_byte
  import midi_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] byte_in,
  output logic       ready,
  output logic       tx
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

  logic          active;
  logic [3:0]    bit_cnt;
  logic [CW-1:0] baud_cnt;
  logic [7:0]    shreg;
  logic          frame_end;

  assign frame_end = active && (bit_cnt == 4'd9) && (baud_cnt == '0);
  assign ready     = !active || frame_end;

  // shreg refills with ones from the top, so the ninth shift yields the stop bit
  always_ff @(posedge clk) begin
    if (rst) begin
      active   <= 1'b0;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      shreg    <= '1;
      tx       <= 1'b1;
    end else if (load && ready) begin
      active   <= 1'b1;
      bit_cnt  <= '0;
      baud_cnt <= RELOAD;
      shreg    <= byte_in;
      tx       <= 1'b0;
    end else if (active) begin
      if (baud_cnt != '0) begin
        baud_cnt <= baud_cnt - CW'(1);
      end else if (frame_end) begin
        active  <= 1'b0;
        bit_cnt <= '0;
        tx      <= 1'b1;
      end else begin
        bit_cnt  <= bit_cnt + 4'd1;
        baud_cnt <= RELOAD;
        tx       <= shreg[0];
        shreg    <= {1'b1, shreg[7:1]};
      end
    end
  end

endmodule

// File: rtl/midi_tx.sv
// rtl/midi_tx.sv - MIDI channel-voice transmitter with optional running status
module midi_tx
  import midi_pkg::*;
#(
  parameter int CLKS_PER_BIT   = CLKS_PER_BIT_DEFAULT,
  parameter int RUNNING_STATUS = 1
) (
  input  logic     clk,
  input  logic     rst,
  midi_tx_if.slave cmd,
  output logic     midi_out,
  output logic     busy
);

  tx_state_e  state;
  logic       ready_q;
  logic [7:0] last_status;
  logic       last_valid;
  logic [6:0] d1_q;
  logic [6:0] d2_q;

  logic [7:0] new_status;
  logic       skip_status;
  logic       accept;
  logic       byte_ready;
  logic       load;
  logic [7:0] byte_in;

  assign cmd.cmd_ready = ready_q;
  assign new_status    = status_byte(cmd.cmd_type, cmd.channel);
  assign skip_status   = (RUNNING_STATUS != 0) && last_valid && (new_status == last_status);
  assign accept        = cmd.cmd_valid && ready_q;

  // The first byte is handed to the serializer on the accept edge so its start bit
  // appears on the very next cycle.
  always_comb begin
    load    = 1'b0;
    byte_in = new_status;
    case (state)
      ST_IDLE: begin
        load    = accept;
        byte_in = skip_status ? {1'b0, cmd.data1} : new_status;
      end
      ST_SEND_STATUS: begin
        load    = byte_ready;
        byte_in = {1'b0, d1_q};
      end
      ST_SEND_D1: begin
        load    = byte_ready;
        byte_in = {1'b0, d2_q};
      end
      default: begin
        load    = 1'b0;
        byte_in = new_status;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      ready_q     <= 1'b1;
      busy        <= 1'b0;
      last_status <= '0;
      last_valid  <= 1'b0;
      d1_q        <= '0;
      d2_q        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            d1_q        <= cmd.data1;
            d2_q        <= cmd.data2;
            ready_q     <= 1'b0;
            busy        <= 1'b1;
            last_status <= new_status;
            last_valid  <= 1'b1;
            state       <= skip_status ? ST_SEND_D1 : ST_SEND_STATUS;
          end
        end
        ST_SEND_STATUS: begin
          if (byte_ready) state <= ST_SEND_D1;
        end
        ST_SEND_D1: begin
          if (byte_ready) state <= ST_SEND_D2;
        end
        default: begin
          if (byte_ready) begin
            state   <= ST_IDLE;
            ready_q <= 1'b1;
            busy    <= 1'b0;
          end
        end
      endcase
    end
  end

  midi_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .byte_in(byte_in),
    .ready  (byte_ready),
    .tx     (midi_out)
  );

endmodule

// File: doc/midi_tx.md
Name: midi_tx

Overview:
MIDI transmitter: the output-side counterpart of the existing MIDI receive and decode path. It accepts one channel-voice event per handshake (note off, note on, control change, pitch bend) and serializes it as a 2- or 3-byte MIDI message. The line is 31250-baud UART, 8N1, idle high, LSB first. It drives a MIDI-out / thru pin from the synth fabric, and the existing `midi` receiver can loop it back in test.

Parameters:
- CLKS_PER_BIT, 3200, clock cycles per bit (100 MHz / 31250); minimum 2.
- RUNNING_STATUS, 1, 1 = omit the status byte when it equals the last status byte sent.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active high
- cmd_valid  input  1  event request
- cmd_ready  output  1  block can accept an event this cycle
- cmd_type  input  2  0 = note off (0x8n), 1 = note on (0x9n), 2 = CC (0xBn), 3 = pitch bend (0xEn)
- channel  input  4  MIDI channel n
- data1  input  7  note / CC number / pitch-bend LSB7
- data2  input  7  velocity / CC value / pitch-bend MSB7
- midi_out  output  1  serial MIDI line
- busy  output  1  high from acceptance until the last stop bit ends

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - midi_out = 1, cmd_ready = 1, busy = 0.
  - Bit counter and baud counter = 0.
  - last_status marked invalid.
- Handshake:
  - An event is accepted on a rising clk edge where cmd_valid && cmd_ready.
  - cmd_type, channel, data1 and data2 are captured on that edge and the inputs are then don't-care.
  - cmd_ready = 1 only in IDLE; cmd_valid while not ready is ignored and must be held by the source.
- Status byte: {1, type_nibble[2:0], channel}. Type nibbles: 0x8, 0x9, 0xB, 0xE. Data bytes: {0, data1} and {0, data2}.
- Running status:
  - If RUNNING_STATUS = 1, last_status is valid and the new status equals last_status, only the 2 data bytes are sent.
  - Otherwise all 3 bytes are sent, and last_status is updated at acceptance.
  - If RUNNING_STATUS = 0, the status byte is always sent.
- FSM: IDLE -> SEND_STATUS (or SEND_D1 if running status applies) -> SEND_D1 -> SEND_D2 -> IDLE.
- Per-byte frame:
  - Start bit 0, then d[0]..d[7], then stop bit 1.
  - Each bit is held exactly CLKS_PER_BIT cycles; a frame is 10*CLKS_PER_BIT cycles.
- Timing:
  - The start bit of the first byte appears on midi_out the cycle after acceptance.
  - Consecutive bytes are back-to-back: the next start bit immediately follows the previous stop bit, with no idle gap.
  - After the last stop bit: IDLE, cmd_ready = 1, busy = 0 on the same cycle.
  - A new event accepted on that cycle starts its frame the next cycle.
- midi_out is registered (glitch-free); the baud counter is a down-counter reloaded at each bit boundary.
- Reset mid-frame: on the cycle after rst, midi_out = 1, the FSM is in IDLE and last_status is invalid. The partially sent message is abandoned; it is not resumed.
- rst asserted together with cmd_valid: reset wins and the event is not accepted.

Decomposition:
- Shared package `midi_pkg`:
  - Status nibble constants: NOTE_OFF = 4'h8, NOTE_ON = 4'h9, CC = 4'hB, PB = 4'hE.
  - cmd_type encoding.
  - Default CLKS_PER_BIT derived from CLK_FREQ and MIDI_BAUD = 31250, shared with the receiver.
- One sub-module, `midi_tx_byte`: 8N1 byte serializer.
  - Ports: clk, rst, load, byte_in[7:0], ready, tx.
  - It owns the baud and bit counters.
  - midi_tx owns the message FSM, running status and handshake.

Test Plan (CLKS_PER_BIT = 4 in simulation; sample midi_out at bit centres):
- Note on, ch 0, data1 = 60, data2 = 100, after reset -> bytes 0x90, 0x3C, 0x64; busy for 120 cycles; cmd_ready returns on the cycle after the final stop bit.
- Same note-on repeated, ch 0, data1 = 62, data2 = 80, with RUNNING_STATUS = 1 -> only 0x3E, 0x50 (80 cycles). With RUNNING_STATUS = 0 -> 0x90, 0x3E, 0x50.
- CC, ch 3, data1 = 7, data2 = 127, then pitch bend, ch 3, 14-bit value 0x2000 (data1 = 0x00, data2 = 0x40) -> 0xB3 0x07 0x7F, then 0xE3 0x00 0x40; the status changes, so both are full messages.
- cmd_valid held high continuously with alternating events -> each event accepted exactly once; the frames are contiguous with no idle bit between messages; inputs changed while busy have no effect.
- rst pulsed for 1 cycle during d[3] of the second byte:
  - Next cycle: midi_out = 1, cmd_ready = 1.
  - The following note on ch 0 sends full status 0x90 even though 0x90 was sent before.
- Loopback into the existing `midi` receiver and `midi_auswert` at full CLKS_PER_BIT = 3200 -> note_on pulses with note_freq = 60 and velocity = 100.
